// File: rtl/countdown_pkg.sv
// Shared types, segment patterns and BCD helpers for countdown_timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Saturate every nibble of a four-digit BCD word to 9.
    function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > BCD_MAX) begin
                r[i*4 +: 4] = BCD_MAX;
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Subtract one from a four-digit BCD word, rippling the borrow upward.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = BCD_MAX;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bundle between the clock top level and countdown_timer.
interface countdown_timer_if;
    logic        load;
    logic [15:0] load_value;
    logic        start_stop;
    logic [6:0]  seg3;
    logic [6:0]  seg2;
    logic [6:0]  seg1;
    logic [6:0]  seg0;
    logic        running;
    logic        expired;
    logic        alarm;

    modport master (
        output load, load_value, start_stop,
        input  seg3, seg2, seg1, seg0, running, expired, alarm
    );

    modport slave (
        input  load, load_value, start_stop,
        output seg3, seg2, seg1, seg0, running, expired, alarm
    );
endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-high 7-segment pattern (bit0=a .. bit6=g); shared with the stopwatch.
module seg7_decode
    import countdown_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup; non-BCD codes show blank.
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_timer.sv
// Four-digit BCD countdown timer with 7-segment outputs.
// Optional feature: define COUNTDOWN_BLINK_EN to blink the 0000 display after expiry.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  bus
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

    state_e         state_q;
    logic [15:0]    digits_q;
    logic           prev_q;
    logic [PW-1:0]  presc_q;
    logic           running_q;
    logic           expired_q;
    logic           alarm_q;
`ifdef COUNTDOWN_BLINK_EN
    logic           blink_q;
`endif

    logic           edge_s;
    logic           wrap_s;
    logic [15:0]    dec_s;
    logic [6:0]     seg3_s, seg2_s, seg1_s, seg0_s;

    assign edge_s = bus.start_stop & ~prev_q;
    assign wrap_s = (presc_q == PRESC_MAX);
    assign dec_s  = bcd_dec(digits_q);

    // Control FSM: load has priority over the start/stop edge; outputs are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            digits_q  <= 16'h0000;
            prev_q    <= 1'b0;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            alarm_q   <= 1'b0;
`ifdef COUNTDOWN_BLINK_EN
            blink_q   <= 1'b0;
`endif
        end else begin
            prev_q  <= bus.start_stop;
            alarm_q <= 1'b0;
            if (bus.load && (state_q != RUN)) begin
                digits_q  <= bcd_clamp(bus.load_value);
                state_q   <= PAUSE;
                presc_q   <= '0;
                running_q <= 1'b0;
                expired_q <= 1'b0;
`ifdef COUNTDOWN_BLINK_EN
                blink_q   <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    PAUSE: begin
                        if (edge_s && (digits_q != 16'h0000)) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                            presc_q   <= '0;
                        end else begin
                            state_q <= PAUSE;
                        end
                    end
                    RUN: begin
                        if (edge_s) begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                            presc_q   <= '0;
                        end else if (wrap_s) begin
                            presc_q  <= '0;
                            digits_q <= dec_s;
                            if (dec_s == 16'h0000) begin
                                state_q   <= DONE;
                                running_q <= 1'b0;
                                expired_q <= 1'b1;
                                alarm_q   <= 1'b1;
                            end else begin
                                state_q <= RUN;
                            end
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    DONE: begin
`ifdef COUNTDOWN_BLINK_EN
                        // Free-running prescaler paces the blink toggle.
                        if (wrap_s) begin
                            presc_q <= '0;
                            blink_q <= ~blink_q;
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
`else
                        presc_q <= '0;
`endif
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    seg7_decode u_dec3 (.bcd_i(digits_q[15:12]), .seg_o(seg3_s));
    seg7_decode u_dec2 (.bcd_i(digits_q[11:8]),  .seg_o(seg2_s));
    seg7_decode u_dec1 (.bcd_i(digits_q[7:4]),   .seg_o(seg1_s));
    seg7_decode u_dec0 (.bcd_i(digits_q[3:0]),   .seg_o(seg0_s));

`ifdef COUNTDOWN_BLINK_EN
    assign bus.seg3 = blink_q ? SEG_BLANK : seg3_s;
    assign bus.seg2 = blink_q ? SEG_BLANK : seg2_s;
    assign bus.seg1 = blink_q ? SEG_BLANK : seg1_s;
    assign bus.seg0 = blink_q ? SEG_BLANK : seg0_s;
`else
    assign bus.seg3 = seg3_s;
    assign bus.seg2 = seg2_s;
    assign bus.seg1 = seg1_s;
    assign bus.seg0 = seg0_s;
`endif

    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed test-plan sequences plus random stimulus,
// checked against a decimal-arithmetic reference model.
module tb_countdown_timer;

    localparam int TD = 4;

    typedef struct packed {
        logic [6:0] s3;
        logic [6:0] s2;
        logic [6:0] s1;
        logic [6:0] s0;
        logic       run;
        logic       exp;
        logic       alm;
    } exp_t;

    logic clk;
    logic reset;
    countdown_timer_if bus();

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks;
    int errors;
    exp_t sb_q[$];

    logic [6:0] seg_tab [10];

    // reference model state: value is a plain decimal integer 0..9999
    int m_val;
    int m_mode;   // 0 idle, 1 paused, 2 running, 3 done
    int m_phase;  // cycles elapsed within the current tick period
    bit m_prev;
    bit m_blink;
    bit m_alarm;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_mode = 0; m_phase = 0; m_prev = 1'b0; m_blink = 1'b0; m_alarm = 1'b0;
    endtask

    function automatic int clamp_to_dec(input logic [15:0] lv);
        int v;
        int d;
        int w;
        v = 0;
        w = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'((lv >> (4 * i)) & 16'h000F);
            if (d > 9) d = 9;
            v = v + d * w;
            w = w * 10;
        end
        return v;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        e.s3  = seg_tab[(m_val / 1000) % 10];
        e.s2  = seg_tab[(m_val / 100) % 10];
        e.s1  = seg_tab[(m_val / 10) % 10];
        e.s0  = seg_tab[m_val % 10];
        if (m_blink) begin
            e.s3 = 7'h00; e.s2 = 7'h00; e.s1 = 7'h00; e.s0 = 7'h00;
        end
        e.run = (m_mode == 2);
        e.exp = (m_mode == 3);
        e.alm = m_alarm;
        return e;
    endfunction

    // One clock of the behavioural model given the inputs sampled at that edge.
    task automatic model_cycle(input bit ld, input logic [15:0] lv, input bit ss);
        bit rise;
        rise   = ss && !m_prev;
        m_prev = ss;
        m_alarm = 1'b0;
        if (ld && m_mode != 2) begin
            m_val = clamp_to_dec(lv); m_mode = 1; m_phase = 0; m_blink = 1'b0;
        end else if (m_mode == 1) begin
            if (rise && m_val != 0) begin m_mode = 2; m_phase = 0; end
        end else if (m_mode == 2) begin
            if (rise) begin
                m_mode = 1; m_phase = 0;
            end else begin
                m_phase = (m_phase + 1) % TD;
                if (m_phase == 0) begin
                    m_val = m_val - 1;
                    if (m_val == 0) begin m_mode = 3; m_alarm = 1'b1; end
                end
            end
        end else if (m_mode == 3) begin
`ifdef COUNTDOWN_BLINK_EN
            m_phase = (m_phase + 1) % TD;
            if (m_phase == 0) m_blink = !m_blink;
`endif
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue what the next edge must produce.
    task automatic step(input bit ld, input logic [15:0] lv, input bit ss);
        @(negedge clk);
        bus.load       = ld;
        bus.load_value = lv;
        bus.start_stop = ss;
        model_cycle(ld, lv, ss);
        sb_q.push_back(model_outputs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_seg3"}, bus.seg3, 7'h3F);
        chk({tag, "_seg2"}, bus.seg2, 7'h3F);
        chk({tag, "_seg1"}, bus.seg1, 7'h3F);
        chk({tag, "_seg0"}, bus.seg0, 7'h3F);
        chk({tag, "_running"}, {6'd0, bus.running}, 7'd0);
        chk({tag, "_expired"}, {6'd0, bus.expired}, 7'd0);
        chk({tag, "_alarm"}, {6'd0, bus.alarm}, 7'd0);
    endtask

    // Monitor: after each rising edge compare DUT outputs with the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("seg3", bus.seg3, e.s3);
            chk("seg2", bus.seg2, e.s2);
            chk("seg1", bus.seg1, e.s1);
            chk("seg0", bus.seg0, e.s0);
            chk("running", {6'd0, bus.running}, {6'd0, e.run});
            chk("expired", {6'd0, bus.expired}, {6'd0, e.exp});
            chk("alarm", {6'd0, bus.alarm}, {6'd0, e.alm});
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        model_reset();
        bus.load = 1'b0; bus.load_value = 16'h0000; bus.start_stop = 1'b0;
        reset = 1'b1;
        #13;
        check_reset_state("reset");
        #10;
        reset = 1'b0;

        // borrow: 1000 -> 0999 one tick after start
        step(1'b1, 16'h1000, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        idle(6);
        // pause and resume
        step(1'b1, 16'h0005, 1'b0);   // ignored: running
        step(1'b0, 16'h0000, 1'b1);   // pause
        step(1'b1, 16'h0005, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        idle(5);
        step(1'b0, 16'h0000, 1'b1);
        idle(20);
        step(1'b0, 16'h0000, 1'b1);
        idle(6);
        step(1'b0, 16'h0000, 1'b1);
        // expiry, then ignored edge and blink/steady display
        step(1'b1, 16'h0002, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        idle(10);
        step(1'b0, 16'h0000, 1'b1);
        idle(20);
        // load guards
        step(1'b1, 16'hA5F3, 1'b0);
        idle(2);
        step(1'b0, 16'h0000, 1'b1);
        idle(3);
        step(1'b1, 16'h1234, 1'b0);   // during run: ignored
        idle(3);
        step(1'b0, 16'h0000, 1'b1);   // pause
        step(1'b0, 16'h0000, 1'b0);
        step(1'b1, 16'h0042, 1'b1);   // load and rising edge together
        idle(6);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        idle(4);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] lv;
            bit ld;
            bit ss;
            lv = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 0) lv = {12'h000, 4'($urandom_range(0, 15))};
            ld = ($urandom_range(0, 31) == 0);
            ss = ($urandom_range(0, 3) == 0);
            step(ld, lv, ss);
        end

        // asynchronous reset in the middle of a run
        step(1'b1, 16'h0777, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        idle(5);
        @(posedge clk);
        #3;
        bus.start_stop = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 16'h0000, 1'b1);   // ignored in idle
        step(1'b1, 16'h0003, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        idle(16);

        // drain the scoreboard within a fixed cycle budget
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
